// File: rtl/udp_cmd_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : udp_cmd_rx_pkg
// Brief    : Shared protocol constants, byte offsets, command codes and FSM
//            encodings for the UDP command transmitter/receiver pair.
// Revision : 1.0 - initial release
// ============================================================================
package udp_cmd_rx_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;

    // Byte offsets counted from the first byte after SFD
    localparam logic [5:0] OFS_MAC      = 6'd0;
    localparam logic [5:0] OFS_TYPE     = 6'd12;
    localparam logic [5:0] OFS_IPHDR    = 6'd14;
    localparam logic [5:0] OFS_PROTO    = 6'd23;
    localparam logic [5:0] OFS_DST_IP   = 6'd30;
    localparam logic [5:0] OFS_UDPHDR   = 6'd34;
    localparam logic [5:0] OFS_DST_PORT = 6'd36;
    localparam logic [5:0] OFS_UDP_LEN  = 6'd38;
    localparam logic [5:0] OFS_PAYLOAD  = 6'd42;

    // Host command codes shared with the transmitter
    localparam logic [7:0] CMD_NOP    = 8'h00;
    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_ETH      = 3'd2,
        ST_IPHDR    = 3'd3,
        ST_UDPHDR   = 3'd4,
        ST_DATA     = 3'd5,
        ST_DROP     = 3'd6
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/udp_cmd_rx_mii_nibble2byte.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mii_nibble2byte
// Brief    : Pairs MII RX nibbles into bytes (low nibble first); byte_valid is
//            combinational with the second nibble of each byte.
// Revision : 1.0 - initial release
// ============================================================================
module mii_nibble2byte (
    input  logic       clk,
    input  logic       clr,
    input  logic       rxdv,
    input  logic [3:0] rxd,
    input  logic       align,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       phase_odd
);

    logic [3:0] r_lo;
    logic       r_phase;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_lo    <= 4'h0;
            r_phase <= 1'b0;
        end else if (!rxdv || align) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            if (!r_phase) r_lo <= rxd;
        end
    end

    assign byte_data  = {rxd, r_lo};
    assign byte_valid = rxdv & r_phase;
    assign phase_odd  = r_phase;

endmodule
`default_nettype wire

// File: rtl/udp_cmd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : udp_cmd_rx
// Brief    : MII RX frame decoder: validates Eth/IPv4/UDP headers and delivers
//            32-bit payload words; first word latched as host command.
//            Optional IPv4 header checksum check: define UDP_RX_IPCSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module udp_cmd_rx
    import udp_cmd_rx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h01606E11020F,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A801B7,
    parameter logic [15:0] LOCAL_PORT = 16'h1F90,
    parameter int          MAX_WORDS  = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        rxdv,
    input  logic [3:0]  rxd,
    output logic [31:0] udp_rx_cmd,
    output logic [31:0] rx_word,
    output logic        rx_word_valid,
    output logic        rx_finish,
    output logic        rx_error,
    output logic [2:0]  state
);

    localparam logic [15:0] c_max_words = 16'(MAX_WORDS);

    rx_state_t   r_state;
    logic [5:0]  r_byte_cnt;
    logic [3:0]  r_pre_cnt;
    logic [7:0]  r_prev;
    logic        r_mac_uc;
    logic        r_mac_bc;
    logic [23:0] r_shift;
    logic [1:0]  r_lane;
    logic [15:0] r_budget;
    logic [15:0] r_words;

    logic [7:0]  w_byte;
    logic        w_byte_valid;
    logic        w_phase_odd;
    logic        w_sfd;
    logic [7:0]  w_exp_byte;
    logic        w_exact;
    logic        w_uc_next;
    logic        w_bc_next;
    logic [15:0] w_len;
    logic [15:0] w_avail;
    logic [15:0] w_budget;
    logic        w_hdr_bad;

    mii_nibble2byte u_n2b (
        .clk        (clk),
        .clr        (clr),
        .rxdv       (rxdv),
        .rxd        (rxd),
        .align      (w_sfd),
        .byte_data  (w_byte),
        .byte_valid (w_byte_valid),
        .phase_odd  (w_phase_odd)
    );

    assign w_sfd = (r_state == ST_PREAMBLE) && rxdv && (rxd == 4'hd) && (r_pre_cnt >= 4'd7);

    always_comb begin
        w_exp_byte = 8'h00;
        w_exact    = 1'b0;
        case (r_byte_cnt)
            6'd0:                 w_exp_byte = LOCAL_MAC[47:40];
            6'd1:                 w_exp_byte = LOCAL_MAC[39:32];
            6'd2:                 w_exp_byte = LOCAL_MAC[31:24];
            6'd3:                 w_exp_byte = LOCAL_MAC[23:16];
            6'd4:                 w_exp_byte = LOCAL_MAC[15:8];
            6'd5:                 w_exp_byte = LOCAL_MAC[7:0];
            OFS_TYPE:             begin w_exp_byte = ETHERTYPE_IPV4[15:8]; w_exact = 1'b1; end
            OFS_TYPE + 6'd1:      begin w_exp_byte = ETHERTYPE_IPV4[7:0];  w_exact = 1'b1; end
            OFS_IPHDR:            begin w_exp_byte = IP_VER_IHL;           w_exact = 1'b1; end
            OFS_PROTO:            begin w_exp_byte = IP_PROTO_UDP;         w_exact = 1'b1; end
            OFS_DST_IP:           begin w_exp_byte = LOCAL_IP[31:24];      w_exact = 1'b1; end
            OFS_DST_IP + 6'd1:    begin w_exp_byte = LOCAL_IP[23:16];      w_exact = 1'b1; end
            OFS_DST_IP + 6'd2:    begin w_exp_byte = LOCAL_IP[15:8];       w_exact = 1'b1; end
            OFS_DST_IP + 6'd3:    begin w_exp_byte = LOCAL_IP[7:0];        w_exact = 1'b1; end
            OFS_DST_PORT:         begin w_exp_byte = LOCAL_PORT[15:8];     w_exact = 1'b1; end
            OFS_DST_PORT + 6'd1:  begin w_exp_byte = LOCAL_PORT[7:0];      w_exact = 1'b1; end
            default:              ;
        endcase
    end

    // Unicast and broadcast matches are tracked separately so mixed bytes fail
    assign w_uc_next = ((r_byte_cnt == OFS_MAC) || r_mac_uc) && (w_byte == w_exp_byte);
    assign w_bc_next = ((r_byte_cnt == OFS_MAC) || r_mac_bc) && (w_byte == 8'hFF);
    assign w_len     = {r_prev, w_byte};
    assign w_avail   = (w_len - 16'd8) >> 2;
    assign w_budget  = (w_avail > c_max_words) ? c_max_words : w_avail;

`ifdef UDP_RX_IPCSUM_EN
    logic [15:0] r_csum;
    logic [16:0] w_csum_sum;
    logic [15:0] w_csum_fold;
    assign w_csum_sum  = {1'b0, r_csum} + {1'b0, w_len};
    assign w_csum_fold = w_csum_sum[15:0] + {15'd0, w_csum_sum[16]};
`endif

    always_comb begin
        w_hdr_bad = 1'b0;
        if (r_state == ST_ETH || r_state == ST_IPHDR || r_state == ST_UDPHDR) begin
            if (w_exact && (w_byte != w_exp_byte))                      w_hdr_bad = 1'b1;
            if ((r_byte_cnt == 6'd5) && !w_uc_next && !w_bc_next)       w_hdr_bad = 1'b1;
            if ((r_byte_cnt == OFS_UDP_LEN + 6'd1) && (w_len < 16'd12)) w_hdr_bad = 1'b1;
`ifdef UDP_RX_IPCSUM_EN
            if ((r_byte_cnt == OFS_UDPHDR - 6'd1) && (w_csum_fold != 16'hFFFF)) w_hdr_bad = 1'b1;
`endif
        end
    end

`ifdef UDP_RX_IPCSUM_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_csum <= 16'h0000;
        end else if (w_sfd) begin
            r_csum <= 16'h0000;
        end else if (w_byte_valid && (r_state == ST_IPHDR) && r_byte_cnt[0]) begin
            r_csum <= w_csum_fold;
        end
    end
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state       <= ST_IDLE;
            r_byte_cnt    <= 6'd0;
            r_pre_cnt     <= 4'd0;
            r_prev        <= 8'h00;
            r_mac_uc      <= 1'b0;
            r_mac_bc      <= 1'b0;
            r_shift       <= 24'h0;
            r_lane        <= 2'd0;
            r_budget      <= 16'd0;
            r_words       <= 16'd0;
            udp_rx_cmd    <= 32'h0;
            rx_word       <= 32'h0;
            rx_word_valid <= 1'b0;
            rx_finish     <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            rx_word_valid <= 1'b0;
            rx_finish     <= 1'b0;
            rx_error      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rxdv) begin
                        r_pre_cnt <= 4'd1;
                        r_state   <= (rxd == 4'h5) ? ST_PREAMBLE : ST_DROP;
                    end
                end
                ST_PREAMBLE: begin
                    if (!rxdv) begin
                        rx_error <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else if (rxd == 4'h5) begin
                        if (r_pre_cnt != 4'hF) r_pre_cnt <= r_pre_cnt + 4'd1;
                    end else if (w_sfd) begin
                        r_byte_cnt <= 6'd0;
                        r_state    <= ST_ETH;
                    end else begin
                        r_state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (!rxdv) r_state <= ST_IDLE;
                end
                default: begin
                    if (!rxdv) begin
                        if ((r_state == ST_DATA) && (r_words != 16'd0) && !w_phase_odd)
                            rx_finish <= 1'b1;
                        else
                            rx_error <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_byte_valid) begin
                        r_prev <= w_byte;
                        if (r_state != ST_DATA) r_byte_cnt <= r_byte_cnt + 6'd1;
                        if (r_byte_cnt <= 6'd5) begin
                            r_mac_uc <= w_uc_next;
                            r_mac_bc <= w_bc_next;
                        end
                        if (r_byte_cnt == OFS_UDP_LEN + 6'd1) r_budget <= w_budget;
                        if (w_hdr_bad) begin
                            r_state <= ST_DROP;
                        end else if (r_state == ST_DATA) begin
                            r_shift <= {r_shift[15:0], w_byte};
                            r_lane  <= r_lane + 2'd1;
                            if ((r_lane == 2'd3) && (r_words < r_budget)) begin
                                rx_word       <= {r_shift, w_byte};
                                rx_word_valid <= 1'b1;
                                r_words       <= r_words + 16'd1;
                                if (r_words == 16'd0) udp_rx_cmd <= {r_shift, w_byte};
                            end
                        end else if (r_byte_cnt == OFS_IPHDR - 6'd1) begin
                            r_state <= ST_IPHDR;
                        end else if (r_byte_cnt == OFS_UDPHDR - 6'd1) begin
                            r_state <= ST_UDPHDR;
                        end else if (r_byte_cnt == OFS_PAYLOAD - 6'd1) begin
                            r_lane  <= 2'd0;
                            r_words <= 16'd0;
                            r_state <= ST_DATA;
                        end
                    end
                end
            endcase
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_udp_cmd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_udp_cmd_rx
// Brief    : Directed self-checking bench for udp_cmd_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_cmd_rx;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        rxdv = 1'b0;
    logic [3:0]  rxd = 4'h0;
    logic [31:0] udp_rx_cmd;
    logic [31:0] rx_word;
    logic        rx_word_valid;
    logic        rx_finish;
    logic        rx_error;
    logic [2:0]  state;

    udp_cmd_rx dut (
        .clk           (clk),
        .clr           (clr),
        .rxdv          (rxdv),
        .rxd           (rxd),
        .udp_rx_cmd    (udp_rx_cmd),
        .rx_word       (rx_word),
        .rx_word_valid (rx_word_valid),
        .rx_finish     (rx_finish),
        .rx_error      (rx_error),
        .state         (state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    `define CHECK(tag, obs, exp) \
        begin \
            checks++; \
            assert ((obs) === (exp)) else begin \
                errors++; \
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp); \
            end \
        end

    int          n_strobe = 0;
    int          n_fin = 0;
    int          n_err = 0;
    int          n_both = 0;
    logic [31:0] last_word = 32'h0;

    always @(negedge clk) begin
        if (rx_word_valid) begin
            n_strobe++;
            last_word = rx_word;
        end
        if (rx_finish) n_fin++;
        if (rx_error) n_err++;
        if (rx_finish && rx_error) n_both++;
    end

    logic [7:0] frame[$];

    task automatic build(input logic [47:0] dmac, input logic [31:0] dip,
                         input logic [15:0] dport, input logic [15:0] ulen,
                         input int nwords, input logic [31:0] w0, input bit bad_csum);
        logic [7:0]  ip[20];
        logic [15:0] totlen;
        logic [31:0] s;
        logic [15:0] csum;
        logic [31:0] w;
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back(dmac[47-8*i -: 8]);
        frame.push_back(8'h02); frame.push_back(8'h00); frame.push_back(8'h00);
        frame.push_back(8'h00); frame.push_back(8'h00); frame.push_back(8'h01);
        frame.push_back(8'h08); frame.push_back(8'h00);
        totlen = 16'd20 + ulen;
        ip = '{8'h45, 8'h00, totlen[15:8], totlen[7:0], 8'h00, 8'h00, 8'h40, 8'h00,
               8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h01,
               dip[31:24], dip[23:16], dip[15:8], dip[7:0]};
        s = 32'h0;
        for (int i = 0; i < 10; i++) s = s + {16'h0, ip[2*i], ip[2*i+1]};
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        csum = ~s[15:0];
        if (bad_csum) csum = csum ^ 16'h0100;
        ip[10] = csum[15:8];
        ip[11] = csum[7:0];
        for (int i = 0; i < 20; i++) frame.push_back(ip[i]);
        frame.push_back(8'h04); frame.push_back(8'hD2);
        frame.push_back(dport[15:8]); frame.push_back(dport[7:0]);
        frame.push_back(ulen[15:8]); frame.push_back(ulen[7:0]);
        frame.push_back(8'h00); frame.push_back(8'h00);
        for (int k = 0; k < nwords; k++) begin
            w = (k == 0) ? w0 : 32'h1000_0000 + k;
            for (int b = 0; b < 4; b++) frame.push_back(w[31-8*b -: 8]);
        end
        frame.push_back(8'hDE); frame.push_back(8'hAD);
        frame.push_back(8'hBE); frame.push_back(8'hEF);
    endtask

    task automatic nib(input logic [3:0] v);
        @(negedge clk);
        rxdv = 1'b1;
        rxd  = v;
    endtask

    // Returns rx_finish/rx_error as seen in the cycle right after rxdv falls
    task automatic send(input int nbytes, input bit odd_nibble, input bit end_frame,
                        output logic fin, output logic err);
        int n;
        logic [7:0] b;
        n = (nbytes < 0) ? frame.size() : nbytes;
        repeat (15) nib(4'h5);
        nib(4'hd);
        for (int i = 0; i < n; i++) begin
            b = frame[i];
            nib(b[3:0]);
            nib(b[7:4]);
        end
        if (odd_nibble) nib(4'h3);
        fin = 1'b0;
        err = 1'b0;
        if (end_frame) begin
            @(negedge clk);
            rxdv = 1'b0;
            rxd  = 4'h0;
            @(posedge clk);
            #1;
            fin = rx_finish;
            err = rx_error;
            repeat (4) @(negedge clk);
        end
    endtask

    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MAC   = 48'h01606E11020F;
    localparam logic [31:0] IP    = 32'hC0A801B7;
    localparam logic [15:0] PORT  = 16'h1F90;

    initial begin
        logic fin, err;
        int s0, f0, e0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        `CHECK("rst_state", state, 3'd0)
        `CHECK("rst_cmd", udp_rx_cmd, 32'h0)
        `CHECK("rst_word", rx_word, 32'h0)
        `CHECK("rst_valid", rx_word_valid, 1'b0)
        `CHECK("rst_finish", rx_finish, 1'b0)
        `CHECK("rst_error", rx_error, 1'b0)
        @(negedge clk);
        clr = 1'b1;
        repeat (3) @(negedge clk);

        // Good broadcast frame, 8 words
        build(BCAST, IP, PORT, 16'd40, 8, 32'hA5A50001, 1'b0);
        s0 = n_strobe; f0 = n_fin; e0 = n_err;
        send(-1, 1'b0, 1'b1, fin, err);
        `CHECK("good_fin_cycle", fin, 1'b1)
        `CHECK("good_err_cycle", err, 1'b0)
        `CHECK("good_strobes", n_strobe - s0, 8)
        `CHECK("good_fin_count", n_fin - f0, 1)
        `CHECK("good_err_count", n_err - e0, 0)
        `CHECK("good_cmd", udp_rx_cmd, 32'hA5A50001)
        `CHECK("good_last_word", last_word, 32'h10000007)
        `CHECK("good_state", state, 3'd0)

        // Wrong destination IP: silently dropped
        build(MAC, 32'hC0A80199, PORT, 16'd40, 8, 32'h11112222, 1'b0);
        s0 = n_strobe; f0 = n_fin; e0 = n_err;
        send(-1, 1'b0, 1'b1, fin, err);
        `CHECK("badip_strobes", n_strobe - s0, 0)
        `CHECK("badip_fin", n_fin - f0, 0)
        `CHECK("badip_err", n_err - e0, 0)
        `CHECK("badip_cmd_kept", udp_rx_cmd, 32'hA5A50001)

        // Wrong port: dropped
        build(MAC, IP, 16'h1F91, 16'd40, 8, 32'h33334444, 1'b0);
        s0 = n_strobe; f0 = n_fin; e0 = n_err;
        send(-1, 1'b0, 1'b1, fin, err);
        `CHECK("badport_strobes", n_strobe - s0, 0)
        `CHECK("badport_fin_err", (n_fin - f0) + (n_err - e0), 0)

        // Truncated at byte 20, then a good frame
        build(BCAST, IP, PORT, 16'd40, 8, 32'hC0DE0002, 1'b0);
        s0 = n_strobe; f0 = n_fin;
        send(20, 1'b0, 1'b1, fin, err);
        `CHECK("trunc_err", err, 1'b1)
        `CHECK("trunc_fin", fin, 1'b0)
        `CHECK("trunc_state", state, 3'd0)
        send(-1, 1'b0, 1'b1, fin, err);
        `CHECK("after_trunc_fin", fin, 1'b1)
        `CHECK("after_trunc_strobes", n_strobe - s0, 8)
        `CHECK("after_trunc_cmd", udp_rx_cmd, 32'hC0DE0002)

        // udp_len 48 (10 words) limited to 8
        build(MAC, IP, PORT, 16'd48, 10, 32'h0BADF00D, 1'b0);
        s0 = n_strobe;
        send(-1, 1'b0, 1'b1, fin, err);
        `CHECK("max_strobes", n_strobe - s0, 8)
        `CHECK("max_fin", fin, 1'b1)
        `CHECK("max_last_word", last_word, 32'h10000007)
        `CHECK("max_cmd", udp_rx_cmd, 32'h0BADF00D)

        // udp_len 12: single word boundary
        build(MAC, IP, PORT, 16'd12, 1, 32'h00C0FFEE, 1'b0);
        s0 = n_strobe;
        send(-1, 1'b0, 1'b1, fin, err);
        `CHECK("len12_strobes", n_strobe - s0, 1)
        `CHECK("len12_fin", fin, 1'b1)
        `CHECK("len12_cmd", udp_rx_cmd, 32'h00C0FFEE)

        // udp_len 8 (< 12): dropped without error
        build(MAC, IP, PORT, 16'd8, 0, 32'h0, 1'b0);
        f0 = n_fin; e0 = n_err;
        send(-1, 1'b0, 1'b1, fin, err);
        `CHECK("len8_fin", n_fin - f0, 0)
        `CHECK("len8_err", n_err - e0, 0)

        // Odd nibble at end: error instead of finish
        build(BCAST, IP, PORT, 16'd40, 8, 32'h12345678, 1'b0);
        send(-1, 1'b1, 1'b1, fin, err);
        `CHECK("odd_err", err, 1'b1)
        `CHECK("odd_fin", fin, 1'b0)

        // clr mid-DATA
        build(BCAST, IP, PORT, 16'd40, 8, 32'h55AA55AA, 1'b0);
        send(50, 1'b0, 1'b0, fin, err);
        #1;
        `CHECK("mid_cmd_loaded", udp_rx_cmd, 32'h55AA55AA)
        `CHECK("mid_state_data", state, 3'd5)
        @(negedge clk);
        clr  = 1'b0;
        rxdv = 1'b0;
        #1;
        `CHECK("clr_state", state, 3'd0)
        `CHECK("clr_cmd", udp_rx_cmd, 32'h0)
        `CHECK("clr_word", rx_word, 32'h0)
        `CHECK("clr_flags", {rx_word_valid, rx_finish, rx_error}, 3'b000)
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        build(BCAST, IP, PORT, 16'd40, 8, 32'h600DF00D, 1'b0);
        send(-1, 1'b0, 1'b1, fin, err);
        `CHECK("post_clr_fin", fin, 1'b1)
        `CHECK("post_clr_cmd", udp_rx_cmd, 32'h600DF00D)

`ifdef UDP_RX_IPCSUM_EN
        build(BCAST, IP, PORT, 16'd40, 8, 32'hBAD0C500, 1'b1);
        s0 = n_strobe; f0 = n_fin; e0 = n_err;
        send(-1, 1'b0, 1'b1, fin, err);
        `CHECK("csum_bad_strobes", n_strobe - s0, 0)
        `CHECK("csum_bad_fin_err", (n_fin - f0) + (n_err - e0), 0)
        `CHECK("csum_bad_cmd", udp_rx_cmd, 32'h600DF00D)
        build(BCAST, IP, PORT, 16'd40, 8, 32'h900DC500, 1'b0);
        send(-1, 1'b0, 1'b1, fin, err);
        `CHECK("csum_good_fin", fin, 1'b1)
        `CHECK("csum_good_cmd", udp_rx_cmd, 32'h900DC500)
`endif

        `CHECK("never_both", n_both, 0)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    `undef CHECK

endmodule
`default_nettype wire
